tlrb_aib_rst_seq: RTL

- Per-die bring-up/reset sequencer sitting directly upstream of the multi-channel TLRB AIB PHY wrapper.
- Drives the PHY's por_in, rstn_in, adap_irstb and adap_rstn_in in the AIB-mandated order.
- Monitors the PHY's por_out / device_detect / rstn_out / adap_rstn_out through synchronizers and reports link_ready or a timeout error.
- One FSM controls all enabled channels in lockstep.

---
 rtl/tlrb_aib_rst_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tlrb_aib_rst_seq.sv
// Bring-up/reset sequencer for the multi-channel TLRB AIB PHY wrapper.
// Releases por/rstn/adap resets in AIB order and reports link_ready or a timeout.
module tlrb_aib_rst_seq #(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int POR_CYC     = 16,
    parameter int REL_CYC     = 8,
    parameter int TMO_CYC     = 1024
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           enable,
    input  logic           ms_nsl,
    input  logic [NCH-1:0] chan_en,
    input  logic           phy_por_out,
    input  logic           phy_device_detect,
    input  logic [NCH-1:0] phy_rstn_out,
    input  logic [NCH-1:0] phy_adap_rstn_out,
    output logic           por_in,
    output logic [NCH-1:0] rstn_in,
    output logic [NCH-1:0] adap_irstb,
    output logic [NCH-1:0] adap_rstn_in,
    output logic           link_ready,
    output logic           seq_error,
    output logic [3:0]     seq_state
);

    localparam int MAX_CYC = (POR_CYC > REL_CYC) ? ((POR_CYC > TMO_CYC) ? POR_CYC : TMO_CYC)
                                                 : ((REL_CYC > TMO_CYC) ? REL_CYC : TMO_CYC);
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam int SW      = 2 + 2 * NCH;

    localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_POR       = 4'd1,
        ST_WAIT_LINK = 4'd2,
        ST_PHY_DLY   = 4'd3,
        ST_WAIT_PHY  = 4'd4,
        ST_ADAP_DLY  = 4'd5,
        ST_WAIT_ADAP = 4'd6,
        ST_READY     = 4'd7,
        ST_ERROR     = 4'd8
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]   en_q, en_d;
    logic [SW-1:0]    sync_q [SYNC_STAGES];

    logic             por_d, link_ready_d, seq_error_d;
    logic [NCH-1:0]   rstn_in_d, adap_d;

    logic [SW-1:0]    sync_s;
    logic             por_out_s, det_s, link_up_s;
    logic [NCH-1:0]   rstn_out_s, adap_out_s;
    logic             phy_ok, adap_ok, ready_drop, abort, tmo;

    // NOTE: the synchronizer chain is a handful of flops, not a RAM, so it takes
    // the reset like any other state and every stage comes up 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {phy_por_out, phy_device_detect, phy_rstn_out, phy_adap_rstn_out};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_s     = sync_q[SYNC_STAGES-1];
    assign por_out_s  = sync_s[SW-1];
    assign det_s      = sync_s[SW-2];
    assign rstn_out_s = sync_s[2*NCH-1:NCH];
    assign adap_out_s = sync_s[NCH-1:0];
    assign link_up_s  = ms_nsl ? ~por_out_s : det_s;

    // Disabled channels count as already released in every wait condition.
    assign phy_ok     = &(rstn_out_s | ~en_q);
    assign adap_ok    = &(adap_out_s | ~en_q);
    assign ready_drop = |(en_q & ~(rstn_out_s & adap_out_s));
    assign abort      = (state_q inside {ST_PHY_DLY, ST_WAIT_PHY, ST_ADAP_DLY, ST_WAIT_ADAP, ST_READY})
                        && (!link_up_s || (state_q == ST_READY && ready_drop));
    assign tmo        = (cnt_q == TMO_LAST);

    // NOTE: every variable gets its default before the case so no path can leave
    // one unassigned and turn it into a latch.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (abort) begin
            state_d = ST_POR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (chan_en != '0) begin
                        en_d    = chan_en;
                        state_d = ST_POR;
                    end
                end
                ST_POR:       if (cnt_q == POR_LAST) state_d = ST_WAIT_LINK;
                ST_WAIT_LINK: if (link_up_s) state_d = ST_PHY_DLY;
                              else if (tmo)  state_d = ST_ERROR;
                ST_PHY_DLY:   if (cnt_q == REL_LAST) state_d = ST_WAIT_PHY;
                ST_WAIT_PHY:  if (phy_ok)    state_d = ST_ADAP_DLY;
                              else if (tmo)  state_d = ST_ERROR;
                ST_ADAP_DLY:  if (cnt_q == REL_LAST) state_d = ST_WAIT_ADAP;
                ST_WAIT_ADAP: if (adap_ok)   state_d = ST_READY;
                              else if (tmo)  state_d = ST_ERROR;
                ST_READY:     state_d = ST_READY;
                ST_ERROR:     state_d = ST_ERROR;
                default:      state_d = ST_IDLE;
            endcase
        end

        if (state_d != state_q)   cnt_d = '0;
        else if (cnt_q != '1)     cnt_d = cnt_q + 1'b1;
        else                      cnt_d = cnt_q;

        // Outputs are registered from the next state so they change together with seq_state.
        por_d        = (state_d == ST_POR) && !ms_nsl;
        rstn_in_d    = (state_d inside {ST_WAIT_PHY, ST_ADAP_DLY, ST_WAIT_ADAP, ST_READY}) ? en_d : '0;
        adap_d       = (state_d inside {ST_WAIT_ADAP, ST_READY}) ? en_d : '0;
        link_ready_d = (state_d == ST_READY);
        seq_error_d  = (state_d == ST_ERROR);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            en_q         <= '0;
            por_in       <= 1'b0;
            rstn_in      <= '0;
            adap_irstb   <= '0;
            adap_rstn_in <= '0;
            link_ready   <= 1'b0;
            seq_error    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            en_q         <= en_d;
            por_in       <= por_d;
            rstn_in      <= rstn_in_d;
            adap_irstb   <= adap_d;
            adap_rstn_in <= adap_d;
            link_ready   <= link_ready_d;
            seq_error    <= seq_error_d;
        end
    end

    assign seq_state = state_q;

endmodule
